// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Execute-stage request/result bundle between the pipeline and the MDU.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_sign.sv
// Operand magnitude on the way in, conditional negation of product/quotient/remainder on the way out.
module mdu_sign #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quot,
  input  logic [WIDTH-1:0]   rem,
  input  logic               neg_lo,
  input  logic               neg_hi,
  output logic               sa_c,
  output logic               sb_c,
  output logic [WIDTH-1:0]   abs_a_c,
  output logic [WIDTH-1:0]   abs_b_c,
  output logic [2*WIDTH-1:0] prod_c,
  output logic [WIDTH-1:0]   quot_c,
  output logic [WIDTH-1:0]   rem_c
);

  assign sa_c    = sgn & a[WIDTH-1];
  assign sb_c    = sgn & b[WIDTH-1];
  assign abs_a_c = sa_c ? -a : a;
  assign abs_b_c = sb_c ? -b : b;

  // neg_lo covers both the full product and the quotient; neg_hi the remainder
  assign prod_c  = neg_lo ? -prod : prod;
  assign quot_c  = neg_lo ? -quot : quot;
  assign rem_c   = neg_hi ? -rem  : rem;

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply path.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave bus
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  mdu_state_e       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [AW-1:0]    acc, acc_n;
  logic [WIDTH-1:0] opnd, opnd_n;
  logic [WIDTH-1:0] hi, hi_n, lo, lo_n;
  logic             is_div, is_div_n;
  logic             neg_lo, neg_lo_n, neg_hi, neg_hi_n;
  logic             busy, busy_n, done, done_n;

  logic               sgn_op_c, sa_c, sb_c;
  logic [WIDTH-1:0]   abs_a_c, abs_b_c, quot_c, rem_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH+1:0]   div_diff_c;

  assign sgn_op_c = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);

  mdu_sign #(.WIDTH(WIDTH)) u_sign (
    .a       (bus.a),
    .b       (bus.b),
    .sgn     (sgn_op_c),
    .prod    (acc[2*WIDTH-1:0]),
    .quot    (acc[WIDTH-1:0]),
    .rem     (acc[2*WIDTH-1:WIDTH]),
    .neg_lo  (neg_lo),
    .neg_hi  (neg_hi),
    .sa_c    (sa_c),
    .sb_c    (sb_c),
    .abs_a_c (abs_a_c),
    .abs_b_c (abs_b_c),
    .prod_c  (prod_c),
    .quot_c  (quot_c),
    .rem_c   (rem_c)
  );

  // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
  assign mul_sum_c  = acc[AW-1:WIDTH] + (WIDTH+1)'(opnd);
  assign div_diff_c = {1'b0, acc[AW-2:WIDTH-1]} - (WIDTH+2)'(opnd);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    opnd_n   = opnd;
    hi_n     = hi;
    lo_n     = lo;
    is_div_n = is_div;
    neg_lo_n = neg_lo;
    neg_hi_n = neg_hi;
    done_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              is_div_n = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
              opnd_n   = abs_b_c;
              acc_n    = AW'(abs_a_c);
              // divide by zero leaves the all-ones quotient unsigned so lo reads all ones
              neg_lo_n = (sa_c ^ sb_c) && !(is_div_n && (bus.b == '0));
              neg_hi_n = is_div_n ? sa_c : (sa_c ^ sb_c);
              cnt_n    = CW'(WIDTH - 1);
              state_n  = S_ITER;
`ifdef MDU_FAST_MUL_EN
              if (!is_div_n) begin
                acc_n   = AW'((2*WIDTH)'(abs_a_c) * (2*WIDTH)'(abs_b_c));
                state_n = S_FIX;
              end
`endif
            end
            MDU_MTHI: hi_n = bus.a;
            MDU_MTLO: lo_n = bus.a;
            default: ;
          endcase
        end
      end

      S_ITER: begin
        if (bus.cancel) begin
          state_n = S_IDLE;
        end else begin
          if (is_div) begin
            acc_n = div_diff_c[WIDTH+1] ? {acc[AW-2:0], 1'b0}
                                        : {div_diff_c[WIDTH:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc_n = acc[0] ? {1'b0, mul_sum_c, acc[WIDTH-1:1]} : {1'b0, acc[AW-1:1]};
          end
          cnt_n = cnt - CW'(1);
          if (cnt == '0) state_n = S_FIX;
        end
      end

      S_FIX: begin
        state_n = S_IDLE;
        if (!bus.cancel) begin
          if (is_div) begin
            hi_n = rem_c;
            lo_n = quot_c;
          end else begin
            {hi_n, lo_n} = prod_c;
          end
          done_n = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      opnd   <= opnd_n;
      hi     <= hi_n;
      lo     <= lo_n;
      is_div <= is_div_n;
      neg_lo <= neg_lo_n;
      neg_hi <= neg_hi_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule

// File: tb/tb_mdu.sv
// Directed and randomized bench for mdu against a 64-bit arithmetic reference model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();
  mdu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: results straight from the arithmetic definition of each op
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    hi = 'x;
    lo = 'x;
    case (op)
      MDU_MULT:  begin p = longint'(sa) * longint'(sb); {hi, lo} = p; end
      MDU_MULTU: begin p = {32'h0, a} * {32'h0, b};     {hi, lo} = p; end
      MDU_DIV: begin
        if (b == 32'h0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 32'h0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      MDU_DIVU: begin
        if (b == 32'h0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
    if (op == MDU_MULT || op == MDU_MULTU) return 1;
`endif
    return W + 1;
  endfunction

  // Issue one op, wait for done, check latency, busy length, result and one-cycle done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int k;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
    k = 0;
    busy_cnt = 0;
    while (!bus.done && k < 100) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(exp_lat(op)));
    check({tag, "_busycyc"}, 64'(busy_cnt), 64'(exp_lat(op)));
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
  endtask

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    logic [2:0]  rop;
    logic        saw_done;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;

    run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(MDU_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         "divu");
    run_op(MDU_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, "div_by0");
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");
    run_op(MDU_DIVU,  32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'hFFFF_FFFF, "divu_by0");
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, "div_ovf");

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(rop, ra, rb, ehi, elo);
      run_op(rop, ra, rb, ehi, elo, $sformatf("rnd%0d_op%0d", i, rop));
    end

    // MTHI/MTLO preload, then cancel a DIV with a stray start mid-flight
    mt(MDU_MTHI, 32'h1234);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_done", 64'(bus.done), 64'd0);
    mt(MDU_MTLO, 32'h5678);
    check("pre_hi", 64'(bus.hi), 64'h1234);
    check("pre_lo", 64'(bus.lo), 64'h5678);

    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd100; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin bus.start = 1'b1; bus.op = MDU_MTHI; bus.a = 32'hDEAD; end
      else if (k == 6) begin bus.start = 1'b1; bus.op = MDU_MULTU; end
      else bus.start = 1'b0;
      if (bus.done) saw_done = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("cancel_pre_busy", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_hi", 64'(bus.hi), 64'h1234);
    check("cancel_lo", 64'(bus.lo), 64'h5678);
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check("cancel_no_done", 64'(saw_done), 64'd0);
    check("cancel_hi_late", 64'(bus.hi), 64'h1234);

    // cancel and start together in IDLE: start is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MDU_MTLO; bus.a = 32'hBAD;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cxl_start_busy", 64'(bus.busy), 64'd0);
    check("cxl_start_lo", 64'(bus.lo), 64'h5678);

    // op 7 behaves as NOP
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'h77;
    @(negedge clk);
    bus.start = 1'b0;
    check("op7_busy", 64'(bus.busy), 64'd0);
    check("op7_hi", 64'(bus.hi), 64'h1234);

    // reset during a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
`ifndef MDU_FAST_MUL_EN
    check("rstmid_pre_busy", 64'(bus.busy), 64'd1);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_hi", 64'(bus.hi), 64'd0);
    check("rstmid_lo", 64'(bus.lo), 64'd0);
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_done", 64'(bus.done), 64'd0);

    mt(MDU_MTHI, 32'hCAFE);
    check("mthi_cafe_hi", 64'(bus.hi), 64'hCAFE);
    check("mthi_cafe_lo", 64'(bus.lo), 64'd0);
    check("mthi_cafe_done", 64'(bus.done), 64'd0);
    check("mthi_cafe_busy", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
